// File: rtl/product_bcd_pkg.sv
// Shared definitions for the signed product to BCD converter:
// default sizes, conversion length and FSM state encoding.
package product_bcd_pkg;

   localparam int IN_W        = 16;
   localparam int DIGITS      = 5;
   localparam int CONV_CYCLES = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decade.
module bcd_digit_adj (
   input  logic [3:0] digit,
   output logic [3:0] adj
);

   always_comb begin
      adj = digit;
      if (digit >= 4'd5) adj = digit + 4'd3;
   end

endmodule

// File: rtl/product_to_bcd.sv
// Converts a signed 16-bit multiplier product {aval, bval} into a sign flag
// and a DIGITS-wide BCD magnitude using a sequential double-dabble.
module product_to_bcd #(
   parameter int IN_W   = product_bcd_pkg::IN_W,
   parameter int DIGITS = product_bcd_pkg::DIGITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [IN_W/2-1:0]     aval,
   input  logic [IN_W/2-1:0]     bval,
   output logic                  busy,
   output logic                  done,
   output logic                  neg,
   output logic [4*DIGITS-1:0]   digits
);

   import product_bcd_pkg::*;

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(CONV_CYCLES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CONV_CYCLES - 1);

   state_e             state;
   state_e             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [BCD_W-1:0]   acc;
   logic [BCD_W-1:0]   acc_adj;
   logic [BCD_W-1:0]   acc_shift;
   logic [IN_W-1:0]    mag;
   logic               neg_cap;
   logic [IN_W-1:0]    prod;
   logic [IN_W-1:0]    prod_mag;

   // Two's-complement magnitude; 16'h8000 maps to 32768 as an unsigned value.
   assign prod     = {aval, bval};
   assign prod_mag = prod[IN_W-1] ? IN_W'(~prod + 1'b1) : prod;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit (acc[4*i +: 4]),
         .adj   (acc_adj[4*i +: 4])
      );
   end

   assign acc_shift = {acc_adj[BCD_W-2:0], mag[IN_W-1]};
   assign busy      = (state != IDLE);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CONV;
         CONV:    if (cnt == LAST_CNT) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         mag     <= '0;
         neg_cap <= 1'b0;
         neg     <= 1'b0;
         digits  <= '0;
         done    <= 1'b0;
      end else begin
         state <= state_next;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cnt     <= '0;
                  acc     <= '0;
                  mag     <= prod_mag;
                  neg_cap <= prod[IN_W-1];
               end
            end
            CONV: begin
               acc <= acc_shift;
               mag <= {mag[IN_W-2:0], 1'b0};
               cnt <= cnt + 1'b1;
            end
            DONE: begin
               // Publish the finished result; outputs hold until the next DONE.
               digits <= acc;
               neg    <= neg_cap;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_product_to_bcd.sv
// Directed-vector scoreboard bench for product_to_bcd.
module tb_product_to_bcd;

   localparam int DIGITS = 5;
   localparam int DW     = 4 * DIGITS;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [7:0]    aval;
   logic [7:0]    bval;
   logic          busy;
   logic          done;
   logic          neg;
   logic [DW-1:0] digits;

   typedef struct {
      logic          neg;
      logic [DW-1:0] digits;
      int            cyc;
   } exp_t;

   exp_t          sb[$];
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;
   logic          last_neg = 1'b0;
   logic [DW-1:0] last_digits = '0;

   product_to_bcd #(.IN_W(16), .DIGITS(DIGITS)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .aval   (aval),
      .bval   (bval),
      .busy   (busy),
      .done   (done),
      .neg    (neg),
      .digits (digits)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no pending conversion (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("neg", {31'd0, neg}, {31'd0, e.neg});
            check("digits", {12'd0, digits}, {12'd0, e.digits});
            check("done_cycle", cyc, e.cyc);
            last_neg    = e.neg;
            last_digits = e.digits;
         end
      end
   end

   task automatic issue(input logic [15:0] p, input logic exp_neg, input logic [DW-1:0] exp_d);
      exp_t e;
      int   guard = 0;
      while (busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      aval     = p[15:8];
      bval     = p[7:0];
      start    = 1'b1;
      e.neg    = exp_neg;
      e.digits = exp_d;
      e.cyc    = cyc + 1 + 17;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((sb.size() != 0 || busy) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      check("drain_pending", sb.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      aval  = '0;
      bval  = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_neg", {31'd0, neg}, 0);
      check("rst_digits", {12'd0, digits}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic magnitudes and signs
      issue(16'h0000, 1'b0, 20'h00000);
      issue(16'h3F01, 1'b0, 20'h16129);
      issue(16'h4000, 1'b0, 20'h16384);
      issue(16'hC080, 1'b1, 20'h16256);
      issue(16'hFFFF, 1'b1, 20'h00001);
      issue(16'h270F, 1'b0, 20'h09999);
      issue(16'h7FFF, 1'b0, 20'h32767);
      issue(16'h8000, 1'b1, 20'h32768);
      wait_idle();

      // Result holds while inputs wander
      aval = 8'h12;
      bval = 8'h34;
      repeat (5) @(negedge clk);
      check("hold_digits", {12'd0, digits}, {12'd0, last_digits});
      check("hold_neg", {31'd0, neg}, {31'd0, last_neg});

      // Restart attempts while busy and in DONE are ignored
      issue(16'h3F01, 1'b0, 20'h16129);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         check("busy_high", {31'd0, busy}, 1);
         if (i == 4) begin
            start = 1'b1;
            aval  = 8'hC0;
            bval  = 8'h80;
         end
         if (i == 5) start = 1'b0;
         if (i == 16) begin
            start = 1'b1;
            aval  = 8'h00;
            bval  = 8'h05;
         end
      end
      @(negedge clk);
      start = 1'b0;
      check("busy_low_after", {31'd0, busy}, 0);
      repeat (20) @(negedge clk);
      check("no_restart", {31'd0, busy}, 0);

      // Inputs toggling during conversion have no effect
      issue(16'hC080, 1'b1, 20'h16256);
      for (int i = 0; i < 18; i++) begin
         aval = 8'($urandom);
         bval = 8'($urandom);
         @(negedge clk);
      end
      wait_idle();

      // Reset mid-conversion aborts with no done
      issue(16'h270F, 1'b0, 20'h09999);
      void'(sb.pop_back());
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_digits", {12'd0, digits}, 0);
      check("abort_neg", {31'd0, neg}, 0);
      check("abort_done", {31'd0, done}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      check("abort_idle", {31'd0, busy}, 0);
      issue(16'hFFFF, 1'b1, 20'h00001);
      issue(16'h0001, 1'b0, 20'h00001);
      issue(16'h8000, 1'b1, 20'h32768);
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/product_to_bcd.md
PRODUCT_TO_BCD -- requirements
Module: product_to_bcd

Interface
REQ-001 Parameter: IN_W, 16, product width in bits, formed as {Aval, Bval}.
REQ-002 Parameter: DIGITS, 5, number of BCD output digits.
REQ-003 Clk  input  1  system clock; all state changes on the rising edge.
REQ-004 Reset  input  1  reset, asynchronous, active-low.
REQ-005 Start  input  1  one-cycle request to convert; driven by the multiplier's finish indication.
REQ-006 Aval  input  8  upper product byte (register A), two's complement MSB side.
REQ-007 Bval  input  8  lower product byte (register B).
REQ-008 Busy  output  1  high while a conversion is in progress.
REQ-009 Done  output  1  one-cycle pulse; the result is valid from this cycle onward.
REQ-010 Neg  output  1  sign of the last converted product.
REQ-011 Digits  output  20  BCD magnitude; [19:16] is ten-thousands and [3:0] is units.

Function
REQ-012 The block SHALL treat P = {Aval, Bval} as a 16-bit signed two's-complement value.
REQ-013 On a Start sample in IDLE, the block SHALL capture Neg = P[15] and Mag = |P| as a 16-bit unsigned value (Mag = ~P + 1 when P[15] = 1).
REQ-014 The state machine SHALL have 3 states: IDLE, CONV and DONE.
REQ-015 State transitions SHALL be:
- IDLE -> CONV on Start; the iteration count and the BCD accumulator clear to 0.
- CONV stays in CONV for exactly 16 cycles, then goes to DONE.
- DONE -> IDLE unconditionally after 1 cycle.
REQ-016 Each CONV cycle SHALL perform double-dabble in this order:
- add 3 to every accumulator digit that is >= 5;
- shift {accumulator, Mag} left 1 bit.
REQ-017 Start sampled at edge k SHALL give Done = 1 in the cycle after edge k+17, with Digits and Neg updated at that same edge.
REQ-018 Busy SHALL be 1 in CONV and DONE, and 0 in IDLE.
REQ-019 Start SHALL be ignored while Busy = 1; an in-flight conversion is not restarted or corrupted.
REQ-020 Start in the same cycle that DONE returns to IDLE SHALL be ignored; a new Start is accepted only in IDLE.
REQ-021 Digits and Neg SHALL hold their last value between Done pulses; Aval and Bval changes after capture have no effect.
REQ-022 Range: the largest magnitude is 32768 (P = 16'h8000). Digits SHALL represent it exactly; every digit is always 0-9.
REQ-023 P = 0 SHALL yield Neg = 0 and Digits = 0; negative zero is not possible.

Reset
REQ-024 Reset low SHALL asynchronously force:
- state = IDLE;
- Busy = 0, Done = 0, Neg = 0;
- Digits = 0;
- the accumulator and iteration count = 0.
REQ-025 Reset during CONV or DONE SHALL abort the conversion with no Done pulse.
REQ-026 The first Start after Reset deasserts SHALL convert normally.

Structure
REQ-027 Package product_bcd_pkg SHALL hold:
- the state enum (IDLE, CONV, DONE);
- IN_W, DIGITS and CONV_CYCLES = 16.
REQ-028 The combinational sub-module bcd_digit_adj (4-bit in, 4-bit out, +3 when >= 5) SHALL be instantiated DIGITS times.
REQ-029 The block SHALL sit downstream of the multiplier and feed the hex display drivers; it contains no input synchronisers.

Verification
REQ-030 P = 16'h0000, Start -> Done after 17 cycles; Neg = 0, Digits = 20'h00000.
REQ-031 P = 16'h3F01 (127*127), Start -> Neg = 0, Digits = 20'h16129; P = 16'h4000 (-128*-128) -> Neg = 0, Digits = 20'h16384.
REQ-032 P = 16'hC080 (-128*127), Start -> Neg = 1, Digits = 20'h16256; P = 16'hFFFF -> Neg = 1, Digits = 20'h00001; P = 16'h8000 -> Neg = 1, Digits = 20'h32768.
REQ-033 Start, then a second Start 5 cycles later with a different P -> exactly one Done, carrying the first P's result; Busy stays high for 17 cycles.
REQ-034 Start, then Reset low at cycle 8 -> Busy = 0, Digits = 0 immediately; no Done; the next Start converts correctly.
REQ-035 Aval and Bval changed every cycle during CONV -> the result matches the value captured at Start.
